// File: rtl/data_sram_responder.sv
// Single-port data RAM behind the CPU data-SRAM request interface.
// Byte-masked writes, fixed-latency reads with a valid strobe, window check and debug counters.
module data_sram_responder #(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned PIPE_W = RD_LAT * 32;

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("data_sram_responder: RD_LAT must be within 1..4");
    end

    logic [31:0]               mem_q [DEPTH];

    logic                      in_win_c;
    logic                      rd_c;
    logic                      wr_c;
    logic [ADDR_W-1:0]         idx_c;
    logic [31:0]               rd_word_c;
    logic                      unused_c;

    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic [RD_LAT-1:0]         err_q, err_d;
    logic [RD_LAT-1:0][31:0]   dat_q, dat_d;
    logic [31:0]               rd_count_q, rd_count_d;
    logic [31:0]               wr_count_q, wr_count_d;

    // Request decode; the requester owns alignment so addr[1:0] is dropped.
    always_comb begin
        in_win_c  = (data_sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
        idx_c     = data_sram_addr[ADDR_W+1:2];
        rd_c      = data_sram_en && (data_sram_we == 4'b0000);
        wr_c      = data_sram_en && (data_sram_we != 4'b0000);
        rd_word_c = (rd_c && in_win_c) ? mem_q[idx_c] : 32'h0;
    end

    assign unused_c = ^data_sram_addr[1:0];

    // Latency pipeline shifts toward the top stage; the top data stage only
    // reloads on a completing read so rdata holds between reads.
    always_comb begin
        vld_d = RD_LAT'({vld_q, rd_c});
        err_d = RD_LAT'({err_q, data_sram_en && !in_win_c});
        dat_d = PIPE_W'({dat_q, rd_word_c});
        if (!vld_d[RD_LAT-1]) begin
            dat_d[RD_LAT-1] = dat_q[RD_LAT-1];
        end
        rd_count_d = rd_count_q + 32'(rd_c);
        wr_count_d = wr_count_q + 32'(wr_c);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q      <= '0;
            err_q      <= '0;
            dat_q      <= '0;
            rd_count_q <= 32'h0;
            wr_count_q <= 32'h0;
        end else begin
            vld_q      <= vld_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    // Array has no reset; out-of-window writes never touch it.
    always_ff @(posedge clk) begin
        if (wr_c && in_win_c) begin
            if (data_sram_we[0]) mem_q[idx_c][7:0]   <= data_sram_wdata[7:0];
            if (data_sram_we[1]) mem_q[idx_c][15:8]  <= data_sram_wdata[15:8];
            if (data_sram_we[2]) mem_q[idx_c][23:16] <= data_sram_wdata[23:16];
            if (data_sram_we[3]) mem_q[idx_c][31:24] <= data_sram_wdata[31:24];
        end
    end

    assign data_sram_rdata = dat_q[RD_LAT-1];
    assign rdata_valid     = vld_q[RD_LAT-1];
    assign addr_err        = err_q[RD_LAT-1];
    assign rd_count        = rd_count_q;
    assign wr_count        = wr_count_q;

endmodule
